ar_channel_router: RTL
======================

AR_CHANNEL_ROUTER -- requirements
Module: ar_channel_router

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 2, number of upstream AR masters (2..8).
REQ-002 SHALL have parameter NUM_SLAVES, default 4, number of downstream AR slaves (1..8).
REQ-003 SHALL have parameter ADDR_W, default 32, address width.
REQ-004 SHALL have parameter LEN_W, default 8, arlen width.
REQ-005 SHALL have parameter SEL_LSB, default 30, LSB of the address field that selects the slave; field width SEL_W = max(1, clog2(NUM_SLAVES)); ID_W = max(1, clog2(NUM_MASTERS)).
REQ-006 SHALL have port ACLK  in  1  the single clock; all logic rises on ACLK.
REQ-007 SHALL have port ARESETN  in  1  asynchronous, active-low reset.
REQ-008 SHALL have ports S_AXI_arvalid  in  NUM_MASTERS and S_AXI_arready  out  NUM_MASTERS, per-master handshake.
REQ-009 SHALL have ports S_AXI_araddr  in  NUM_MASTERS*ADDR_W, S_AXI_arlen  in  NUM_MASTERS*LEN_W, S_AXI_arsize  in  NUM_MASTERS*3, S_AXI_arburst  in  NUM_MASTERS*2, S_AXI_arqos  in  NUM_MASTERS*4, flattened per-master payload, master i at slice i.
REQ-010 SHALL have ports M_AXI_arvalid  out  NUM_SLAVES and M_AXI_arready  in  NUM_SLAVES, per-slave handshake.
REQ-011 SHALL have ports M_AXI_araddr_ID  out  ID_W, M_AXI_araddr  out  ADDR_W, M_AXI_arlen  out  LEN_W, M_AXI_arsize  out  3, M_AXI_arburst  out  2, M_AXI_arqos  out  4, registered payload broadcast to all slaves.
REQ-012 SHALL have ports AR_Decerr  out  1 and AR_Decerr_ID  out  ID_W, one-cycle decode-error pulse and the offending master.

Function
REQ-013 SHALL implement FSM IDLE -> ISSUE -> IDLE; IDLE accepts, ISSUE presents to the slave.
REQ-014 In IDLE with any S_AXI_arvalid high, SHALL pick one winner combinationally, assert only its S_AXI_arready that cycle, and latch its payload, its index into M_AXI_araddr_ID, and slave index = araddr[SEL_LSB +: SEL_W].
REQ-015 The arbitration SHALL be round-robin: search starts at (last winner + 1) mod NUM_MASTERS; the pointer updates only on acceptance; after reset the pointer SHALL make master 0 first.
REQ-016 On acceptance with slave index < NUM_SLAVES, SHALL enter ISSUE and assert M_AXI_arvalid[index] on the next cycle (1-cycle latency); all other M_AXI_arvalid bits SHALL stay low.
REQ-017 In ISSUE, M_AXI_arvalid and the payload SHALL hold stable until M_AXI_arready[index] is high, then SHALL deassert next cycle and return to IDLE; minimum 2 cycles per transfer.
REQ-018 In ISSUE, all S_AXI_arready SHALL be low; ready from non-selected slaves SHALL be ignored.
REQ-019 On acceptance with slave index >= NUM_SLAVES, SHALL stay in IDLE, assert no M_AXI_arvalid, and pulse AR_Decerr for one cycle with AR_Decerr_ID = winner the following cycle.
REQ-020 Arbitration changes while a master is in ISSUE SHALL NOT alter the latched payload; a master deasserting valid in IDLE without ready SHALL simply lose the request (no latch).

Reset
REQ-021 ARESETN low SHALL force immediately: state IDLE, M_AXI_arvalid = 0, S_AXI_arready = 0, AR_Decerr = 0, payload and ID registers = 0, RR pointer = last master.
REQ-022 Reset asserted in ISSUE SHALL drop the in-flight request without completing it; the first acceptance after release SHALL be no earlier than the first ACLK edge with ARESETN high.

Configuration
REQ-023 With AR_QOS_ARB_EN defined, SHALL restrict the candidates to the valid masters with the highest arqos, then apply round-robin among them; without it, arqos SHALL be ignored for arbitration (still forwarded).

Verification
REQ-024 Reset, then master 0 valid with araddr 0x4000_0000, arlen 3; M_AXI_arready[1] held high -> S_AXI_arready[0] high in cycle 0; M_AXI_arvalid = 4'b0010 in cycle 1 only; arlen 3; araddr_ID 0.
REQ-025 Masters 0 and 1 continuously valid to slave 0 with ready always high -> grants alternate 0,1,0,1; one transfer every 2 cycles.
REQ-026 M_AXI_arready[2] low for 5 cycles in ISSUE while a master changes its inputs -> M_AXI_arvalid[2] and the payload stay stable for 5 cycles, no S_AXI_arready, completion on cycle 6.
REQ-027 NUM_SLAVES=3, araddr 0xC000_0000 from master 1 -> S_AXI_arready[1] pulse; no M_AXI_arvalid; AR_Decerr = 1 for one cycle with ID 1.
REQ-028 With AR_QOS_ARB_EN, master 0 qos 2 and master 1 qos 9 both valid -> master 1 wins repeatedly; without the macro -> alternation.
REQ-029 ARESETN pulsed low in ISSUE -> M_AXI_arvalid = 0 asynchronously; after release, master 0 wins first.

Source files
------------

// File: rtl/ar_channel_router.sv
// AXI read-address router: round-robin arbitration of NUM_MASTERS AR channels onto NUM_SLAVES slaves.
// Define AR_QOS_ARB_EN to arbitrate among the highest-arqos requesters only.
module ar_channel_router #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned NUM_SLAVES  = 4,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned LEN_W       = 8,
    parameter int unsigned SEL_LSB     = 30,
    localparam int unsigned SEL_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1,
    localparam int unsigned ID_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic [NUM_MASTERS-1:0]        S_AXI_arvalid,
    output logic [NUM_MASTERS-1:0]        S_AXI_arready,
    input  logic [NUM_MASTERS*ADDR_W-1:0] S_AXI_araddr,
    input  logic [NUM_MASTERS*LEN_W-1:0]  S_AXI_arlen,
    input  logic [NUM_MASTERS*3-1:0]      S_AXI_arsize,
    input  logic [NUM_MASTERS*2-1:0]      S_AXI_arburst,
    input  logic [NUM_MASTERS*4-1:0]      S_AXI_arqos,
    output logic [NUM_SLAVES-1:0]         M_AXI_arvalid,
    input  logic [NUM_SLAVES-1:0]         M_AXI_arready,
    output logic [ID_W-1:0]               M_AXI_araddr_ID,
    output logic [ADDR_W-1:0]             M_AXI_araddr,
    output logic [LEN_W-1:0]              M_AXI_arlen,
    output logic [2:0]                    M_AXI_arsize,
    output logic [1:0]                    M_AXI_arburst,
    output logic [3:0]                    M_AXI_arqos,
    output logic                          AR_Decerr,
    output logic [ID_W-1:0]               AR_Decerr_ID
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic [3:0]        qos;
    } payload_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    payload_t               pl_q, pl_d;
    logic [ID_W-1:0]        id_q, id_d;
    logic [ID_W-1:0]        ptr_q, ptr_d;
    logic [NUM_SLAVES-1:0]  arvalid_q, arvalid_d;
    logic                   decerr_q, decerr_d;
    logic [ID_W-1:0]        decerr_id_q, decerr_id_d;

    payload_t               mpl [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] cand;
    logic [NUM_MASTERS-1:0] grant;
    logic                   found;
    logic [ID_W-1:0]        win_id;
    logic [SEL_W-1:0]       win_sel;
    int unsigned            idx;
`ifdef AR_QOS_ARB_EN
    logic [3:0]             max_qos;
`endif

    // Unpack the flattened per-master payload buses
    always_comb begin
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            mpl[i].addr  = S_AXI_araddr[i*ADDR_W +: ADDR_W];
            mpl[i].len   = S_AXI_arlen[i*LEN_W +: LEN_W];
            mpl[i].size  = S_AXI_arsize[i*3 +: 3];
            mpl[i].burst = S_AXI_arburst[i*2 +: 2];
            mpl[i].qos   = S_AXI_arqos[i*4 +: 4];
        end
    end

    // Candidate selection, round-robin search, next-state and register updates
    always_comb begin
        state_d     = state_q;
        pl_d        = pl_q;
        id_d        = id_q;
        ptr_d       = ptr_q;
        arvalid_d   = arvalid_q;
        decerr_d    = 1'b0;
        decerr_id_d = decerr_id_q;
        grant       = '0;
        found       = 1'b0;
        win_id      = '0;
        win_sel     = '0;
        idx         = 0;

`ifdef AR_QOS_ARB_EN
        max_qos = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (S_AXI_arvalid[i] && (mpl[i].qos > max_qos)) begin
                max_qos = mpl[i].qos;
            end
        end
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            cand[i] = S_AXI_arvalid[i] && (mpl[i].qos == max_qos);
        end
`else
        cand = S_AXI_arvalid;
`endif

        // First candidate strictly after the last winner, wrapping
        for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
            idx = 32'(ptr_q) + 1 + k;
            if (idx >= NUM_MASTERS) begin
                idx = idx - NUM_MASTERS;
            end
            if (!found && cand[idx[ID_W-1:0]]) begin
                found  = 1'b1;
                win_id = ID_W'(idx);
            end
        end

        case (state_q)
            IDLE: begin
                if (ARESETN && found) begin
                    grant[win_id] = 1'b1;
                    ptr_d         = win_id;
                    pl_d          = mpl[win_id];
                    id_d          = win_id;
                    win_sel       = mpl[win_id].addr[SEL_LSB +: SEL_W];
                    if (32'(win_sel) < NUM_SLAVES) begin
                        state_d = ISSUE;
                        for (int unsigned s = 0; s < NUM_SLAVES; s++) begin
                            arvalid_d[s] = (32'(win_sel) == s);
                        end
                    end else begin
                        decerr_d    = 1'b1;
                        decerr_id_d = win_id;
                    end
                end
            end
            ISSUE: begin
                if (|(M_AXI_arready & arvalid_q)) begin
                    state_d   = IDLE;
                    arvalid_d = '0;
                end
            end
            default: begin
                state_d   = IDLE;
                arvalid_d = '0;
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= IDLE;
            pl_q        <= '0;
            id_q        <= '0;
            ptr_q       <= ID_W'(NUM_MASTERS - 1);
            arvalid_q   <= '0;
            decerr_q    <= 1'b0;
            decerr_id_q <= '0;
        end else begin
            state_q     <= state_d;
            pl_q        <= pl_d;
            id_q        <= id_d;
            ptr_q       <= ptr_d;
            arvalid_q   <= arvalid_d;
            decerr_q    <= decerr_d;
            decerr_id_q <= decerr_id_d;
        end
    end

    assign S_AXI_arready   = grant;
    assign M_AXI_arvalid   = arvalid_q;
    assign M_AXI_araddr_ID = id_q;
    assign M_AXI_araddr    = pl_q.addr;
    assign M_AXI_arlen     = pl_q.len;
    assign M_AXI_arsize    = pl_q.size;
    assign M_AXI_arburst   = pl_q.burst;
    assign M_AXI_arqos     = pl_q.qos;
    assign AR_Decerr       = decerr_q;
    assign AR_Decerr_ID    = decerr_id_q;

endmodule
